sensor_node_controller: RTL
===========================

// Module: sensor_node_controller
//
// PURPOSE
//  Parametrised successor of the node controller. Samples N_SENSORS channels round-robin into a circular
//  buffer in external memory, drains the buffer to the radio (FLUSH), and stores radio-received words.
//  Sits between the sensor front-ends, the data memory and the radio. Unidirectional buses, valid/ack handshakes.
//
// PARAMETERS
//  DATA_W    8   data word width (sensor, memory, radio)
//  ADDR_W    4   memory address width; buffer DEPTH = 2**ADDR_W words
//  N_SENSORS 4   number of sensor channels (>=1)
//  TIMEOUT   64  max cycles to wait for sensor_valid / radio_rx_valid before skipping (>=1)
//
// PORTS
//  clk            in   1              system clock, all logic on rising edge
//  rst            in   1              asynchronous reset, active-high
//  enable         in   1              synchronous run enable; low = abort to IDLE
//  inst           in   2              00 NOP, 01 SAMPLE, 10 FLUSH, 11 RECEIVE
//  inst_valid     in   1              inst accepted when high and busy low
//  busy           out  1              high while an instruction executes
//  error          out  2              sticky: [0] overflow (sample dropped), [1] timeout
//  count          out  ADDR_W+1       words currently buffered (0..DEPTH)
//  sensor_enable  out  N_SENSORS      one-hot request to channel being sampled
//  sensor_valid   in   N_SENSORS      per-channel data valid
//  sensor_data    in   N_SENSORS*DATA_W  channel k at [k*DATA_W +: DATA_W]
//  mem_addr       out  ADDR_W         memory address
//  mem_wdata      out  DATA_W         memory write data
//  mem_we         out  1              write request, held until mem_ack
//  mem_re         out  1              read request, held until mem_ack
//  mem_rdata      in   DATA_W         read data, valid in mem_ack cycle of a read
//  mem_ack        in   1              memory completes current request
//  radio_enable   out  1              radio powered for TX or RX
//  radio_tx_valid out  1              TX word valid; data held stable until radio_tx_ready
//  radio_tx_data  out  DATA_W         TX word
//  radio_tx_ready in   1              radio accepts TX word
//  radio_rx_valid in   1              RX word available
//  radio_rx_data  in   DATA_W         RX word
//
// BEHAVIOUR
//  - Reset (async): all outputs 0; wr_ptr, rd_ptr, count, error, channel index, timeout counter = 0; state IDLE.
//  - enable low (sync): next edge -> IDLE, all request/enable outputs 0, busy 0; pointers/count/error kept.
//  - States: IDLE, SENSE, MEM_WR, MEM_RD, TX, RX.
//  - IDLE: on inst_valid & enable: NOP ignored; else clear error, busy<=1 next edge.
//    SAMPLE: ch=0 -> SENSE; RECEIVE -> RX; FLUSH -> MEM_RD if count>0, else 1 busy cycle then IDLE.
//  - SENSE: sensor_enable[ch]=1; on sensor_valid[ch] latch data -> MEM_WR.
//    TIMEOUT cycles without valid -> error[1]=1, skip channel. After last channel -> IDLE.
//  - MEM_WR: if count==DEPTH: no write, error[0]=1, continue. Else mem_we=1, mem_addr=wr_ptr,
//    held until mem_ack; then wr_ptr+1 (wraps DEPTH-1 -> 0), count+1. Then next channel (SAMPLE) or IDLE (RECEIVE).
//  - RX: radio_enable=1; on radio_rx_valid latch data -> MEM_WR (one word per RECEIVE).
//    TIMEOUT -> error[1]=1 -> IDLE.
//  - MEM_RD: mem_re=1, mem_addr=rd_ptr until mem_ack; latch mem_rdata -> TX.
//  - TX: radio_enable=1, radio_tx_valid=1, data stable; on radio_tx_ready rd_ptr+1 (wrap), count-1;
//    count==0 after decrement -> IDLE, else MEM_RD.
//  - mem_ack/radio_tx_ready are only sampled while the matching request is high; they are ignored otherwise.
//  - mem_we and mem_re are never high together. sensor_enable is at most one-hot.
//  - Latency: SAMPLE accepted at edge E -> sensor_enable[0] at E+1. sensor_valid seen at edge V -> mem_we at V+1.
//  - count and pointers do not change in an aborted operation unless mem_ack or tx_ready was already taken.
//
// TESTING
//  1 N=2, sensor data 0x11/0x22, valid 2 cycles after enable, ack 1 cycle -> addr0=0x11, addr1=0x22, count=2.
//  2 FLUSH with count=2, radio_tx_ready delayed 3 cycles -> tx_data 0x11 held stable 3 cycles, then 0x22; count=0, busy 0.
//  3 ADDR_W=3: 8 samples, then SAMPLE again -> no mem_we, error[0]=1, count=8; FLUSH 8, then SAMPLE writes addr 0 (wrap).
//  4 Channel 1 never valid, TIMEOUT=16 -> skipped after 16 cycles, error[1]=1, only channels 0,2,3 written.
//  5 RECEIVE, rx_valid with 0x5A -> write 0x5A at wr_ptr, count+1; FLUSH on empty buffer -> busy 1 cycle, no tx_valid.
//  6 rst pulsed mid-write (mem_we=1, no ack) -> outputs 0 without waiting for clk; count=0; enable low mid-TX -> IDLE, count kept.

Source files
------------

// File: rtl/sensor_node_controller.sv
// Node controller: round-robin sensor sampling into a circular buffer held in
// external memory, buffer drain to the radio, and storage of radio-received words.
module sensor_node_controller #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int N_SENSORS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [1:0]                  inst,
  input  logic                        inst_valid,
  output logic                        busy,
  output logic [1:0]                  error,
  output logic [ADDR_W:0]             count,
  output logic [N_SENSORS-1:0]        sensor_enable,
  input  logic [N_SENSORS-1:0]        sensor_valid,
  input  logic [N_SENSORS*DATA_W-1:0] sensor_data,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack,
  output logic                        radio_enable,
  output logic                        radio_tx_valid,
  output logic [DATA_W-1:0]           radio_tx_data,
  input  logic                        radio_tx_ready,
  input  logic                        radio_rx_valid,
  input  logic [DATA_W-1:0]           radio_rx_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CH_W  = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SENSE, MEM_WR, MEM_RD, TX, RX} state_t;
  typedef enum logic [1:0] {I_NOP, I_SAMPLE, I_FLUSH, I_RECEIVE} inst_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        err_q, err_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rx_mode_q, rx_mode_d;
  logic              busy_q, busy_d;
  logic              full, last_ch, tmo_last, wr_done;

  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign last_ch  = (ch_q == CH_W'(N_SENSORS - 1));
  assign tmo_last = (tmo_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= '0;
      ch_q      <= '0;
      tmo_q     <= '0;
      data_q    <= '0;
      rx_mode_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      ch_q      <= ch_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      rx_mode_q <= rx_mode_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    ch_d      = ch_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    rx_mode_d = rx_mode_q;
    busy_d    = busy_q;
    wr_done   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // busy set while idle only marks the single cycle of a FLUSH on an empty buffer
          if (busy_q) begin
            busy_d = 1'b0;
          end else if (inst_valid && inst_t'(inst) != I_NOP) begin
            err_d  = '0;
            busy_d = 1'b1;
            tmo_d  = '0;
            case (inst_t'(inst))
              I_SAMPLE:  begin ch_d = '0; rx_mode_d = 1'b0; state_d = SENSE; end
              I_RECEIVE: begin rx_mode_d = 1'b1; state_d = RX; end
              I_FLUSH:   if (count_q != '0) state_d = MEM_RD;
              default: ;
            endcase
          end
        end
        SENSE: begin
          if (sensor_valid[ch_q]) begin
            data_d  = sensor_data[ch_q*DATA_W +: DATA_W];
            tmo_d   = '0;
            state_d = MEM_WR;
          end else if (tmo_last) begin
            err_d[1] = 1'b1;
            tmo_d    = '0;
            if (last_ch) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        MEM_WR: begin
          if (full) begin
            err_d[0] = 1'b1;
            wr_done  = 1'b1;
          end else if (mem_ack) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            wr_done  = 1'b1;
          end
          if (wr_done) begin
            if (rx_mode_q || last_ch) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = SENSE;
            end
          end
        end
        RX: begin
          if (radio_rx_valid) begin
            data_d  = radio_rx_data;
            tmo_d   = '0;
            state_d = MEM_WR;
          end else if (tmo_last) begin
            err_d[1] = 1'b1;
            tmo_d    = '0;
            state_d  = IDLE;
            busy_d   = 1'b0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            data_d  = mem_rdata;
            state_d = TX;
          end
        end
        TX: begin
          if (radio_tx_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            if (count_q == (ADDR_W+1)'(1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = MEM_RD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign error          = err_q;
  assign count          = count_q;
  assign mem_we         = (state_q == MEM_WR) && !full;
  assign mem_re         = (state_q == MEM_RD);
  assign mem_addr       = mem_re ? rd_ptr_q : (mem_we ? wr_ptr_q : '0);
  assign mem_wdata      = mem_we ? data_q : '0;
  assign sensor_enable  = (state_q == SENSE) ? (N_SENSORS'(1) << ch_q) : '0;
  assign radio_enable   = (state_q == TX) || (state_q == RX);
  assign radio_tx_valid = (state_q == TX);
  assign radio_tx_data  = (state_q == TX) ? data_q : '0;

endmodule
